// File: rtl/prog_loader.sv
// prog_loader: boot-time loader for framed instruction words.
// Holds the core in reset until a frame with a good checksum is written.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset_n,
  output logic              done,
  output logic              err
);

  localparam int MAX_N = (ADDR_W >= 8) ? 255 : (1 << ADDR_W);
  localparam logic [7:0] HDR = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, LEN, HI, LO, WR, CHK, RUN
  } state_t;

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          n_q, n_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          xor_q, xor_d;
  logic                rstn_q, rstn_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                acc;

  assign acc         = in_valid && rdy_q;
  assign in_ready    = rdy_q;
  assign imem_we     = (state_q == WR);
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign cpu_reset_n = rstn_q;
  assign done        = done_q;
  assign err         = err_q;

  // frame parser: next state, datapath and status updates
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    rstn_d  = rstn_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (acc && in_data == HDR) state_d = LEN;
      end
      LEN: begin
        if (acc) begin
          n_d    = in_data;
          cnt_d  = '0;
          addr_d = '0;
          xor_d  = '0;
          if (in_data != 8'd0 && int'(in_data) <= MAX_N) begin
            state_d = HI;
            done_d  = 1'b0;
            err_d   = 1'b0;
            rstn_d  = 1'b0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      HI: begin
        if (acc) begin
          wdata_d[15:8] = in_data;
          xor_d         = xor_q ^ in_data;
          state_d       = LO;
        end
      end
      LO: begin
        if (acc) begin
          wdata_d[7:0] = in_data;
          xor_d        = xor_q ^ in_data;
          state_d      = WR;
        end
      end
      WR: begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_d == n_q) ? CHK : HI;
      end
      CHK: begin
        if (acc) begin
          if (in_data == xor_q) begin
            done_d  = 1'b1;
            rstn_d  = 1'b1;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
            rstn_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      RUN: begin
        if (acc && in_data == HDR) begin
          state_d = LEN;
          rstn_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d != WR);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      rstn_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames with a write scoreboard.
// Expected writes are queued by stimulus and popped by a monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset_n;
  logic        done;
  logic        err;

  prog_loader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset_n(cpu_reset_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  chk_rdy = 1'b0;
  bit  gaps = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // write monitor: pops one expected write per imem_we cycle
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, imem_addr}, {24'd0, e.a});
        check("wr_data", {16'd0, imem_wdata}, {16'd0, e.d});
      end
    end
    if (chk_rdy)
      check("ready_vs_we", {31'd0, in_ready}, {31'd0, !imem_we});
  end

  // present one byte from a falling edge until it is accepted
  task automatic send(input logic [7:0] b);
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %0h ready %0b, needed 1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic word(input logic [7:0] a,
                      input logic [7:0] h,
                      input logic [7:0] l);
    exp_q.push_back({a, h, l});
    send(h);
    send(l);
  endtask

  task automatic status(input string name,
                        input logic rn,
                        input logic dn,
                        input logic er);
    check(name, {29'd0, cpu_reset_n, done, err}, {29'd0, rn, dn, er});
  endtask

  task automatic good_frame();
    send(8'hA5);
    send(8'h02);
    word(8'd0, 8'h12, 8'h34);
    word(8'd1, 8'hAB, 8'hCD);
    send(8'h40);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outs",
          {3'd0, in_ready, imem_we, cpu_reset_n, done, err,
           imem_addr, imem_wdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    chk_rdy = 1'b1;

    good_frame();
    status("good_done", 1'b1, 1'b1, 1'b0);

    send(8'hA5);
    status("reload_drop", 1'b0, 1'b0, 1'b0);
    send(8'h02);
    word(8'd0, 8'h12, 8'h34);
    word(8'd1, 8'hAB, 8'hCD);
    send(8'h41);
    status("bad_cksum", 1'b0, 1'b0, 1'b1);

    send(8'hA5);
    status("err_held", 1'b0, 1'b0, 1'b1);
    send(8'h02);
    status("err_cleared_len", 1'b0, 1'b0, 1'b0);
    word(8'd0, 8'h12, 8'h34);
    word(8'd1, 8'hAB, 8'hCD);
    send(8'h40);
    status("good_after_bad", 1'b1, 1'b1, 1'b0);

    chk_rdy = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_rdy = 1'b1;
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    status("garbage_ignored", 1'b0, 1'b0, 1'b0);
    good_frame();
    status("garbage_then_good", 1'b1, 1'b1, 1'b0);

    send(8'hA5);
    send(8'h00);
    status("len_zero", 1'b0, 1'b0, 1'b1);

    gaps = 1'b1;
    send(8'hA5);
    send(8'h04);
    word(8'd0, 8'h01, 8'h02);
    word(8'd1, 8'h03, 8'h04);
    word(8'd2, 8'h05, 8'h06);
    word(8'd3, 8'h07, 8'h08);
    send(8'h08);
    gaps = 1'b0;
    status("gapped_frame", 1'b1, 1'b1, 1'b0);

    send(8'hA5);
    status("run_reload", 1'b0, 1'b0, 1'b0);
    send(8'h01);
    word(8'd0, 8'hBE, 8'hEF);
    send(8'h51);
    status("reload_done", 1'b1, 1'b1, 1'b0);

    send(8'hA5);
    send(8'h03);
    send(8'h12);
    chk_rdy = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset",
          {3'd0, in_ready, imem_we, cpu_reset_n, done, err,
           imem_addr, imem_wdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_rdy = 1'b1;
    send(8'hA5);
    send(8'h01);
    word(8'd0, 8'h55, 8'hAA);
    send(8'hFF);
    status("after_reset_load", 1'b1, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("no_pending_writes", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
